alu_issuer: RTL and testbench

Instruction-side front end for the integer ALU/multiplier datapath. Accepts one decoded R-type instruction and its register operands through a valid/ready handshake, and drives the datapath's `dataA`, `dataB` and `Signal` inputs for the required number of cycles. It then captures the datapath `Output` and returns a tagged result through a second valid/ready handshake. Only one instruction is in flight at a time, so MFHI/MFLO after MULTU are always ordered correctly.

---
 rtl/alu_issuer_if.sv | 31 +++
 rtl/alu_issuer.sv | 196 +++++++++++++++++++
 tb/tb_alu_issuer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_issuer_if.sv
// Handshake and datapath bundle between the ALU issuer and its environment.
// The slave modport is the issuer's view; the master modport is the surrounding logic.
interface alu_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_output;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_err;

  modport slave (
    input  in_valid, instr, rs_val, rt_val, alu_output, out_ready,
    output in_ready, alu_dataA, alu_dataB, alu_signal,
           out_valid, out_data, out_rd, out_we, out_err
  );

  modport master (
    output in_valid, instr, rs_val, rt_val, alu_output, out_ready,
    input  in_ready, alu_dataA, alu_dataB, alu_signal,
           out_valid, out_data, out_rd, out_we, out_err
  );
endinterface

// File: rtl/alu_issuer.sv
// Single-issue front end: decodes one R-type instruction, drives the ALU/multiplier
// datapath for the needed cycles, then returns the tagged result over valid/ready.
module alu_issuer #(
  parameter int ALU_LAT    = 1,
  parameter int MUL_CYCLES = 32,
  parameter int HILO_LAT   = 1
) (
  input  logic         clk,
  input  logic         reset,
  alu_issuer_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MULW = 3'd2;
  localparam logic [2:0] S_HILO = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [5:0] F_NOP   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  // MULW/HILO leave on the cycle the counter reads 0, so they preload N-1.
  localparam logic [6:0] ALU_CNT0  = 7'(ALU_LAT);
  localparam logic [6:0] MUL_CNT0  = 7'(MUL_CYCLES - 1);
  localparam logic [6:0] HILO_CNT0 = 7'(HILO_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [5:0]  sig_q, sig_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d, err_q, err_d, vld_q, vld_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic        legal, is_mul;
  logic [31:0] dec_a, dec_b;
  logic        unused_fields;

  assign opcode        = bus.instr[31:26];
  assign funct         = bus.instr[5:0];
  assign shamt         = bus.instr[10:6];
  assign unused_fields = ^bus.instr[25:16];

  always_comb begin
    legal  = 1'b0;
    is_mul = 1'b0;
    dec_a  = bus.rs_val;
    dec_b  = bus.rt_val;
    if (opcode == 6'd0) begin
      case (funct)
        F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
        F_SRL: begin
          legal = 1'b1;
          dec_a = bus.rt_val;
          dec_b = {27'b0, shamt};
        end
        F_MULTU: begin
          legal  = 1'b1;
          is_mul = 1'b1;
        end
        F_MFHI, F_MFLO: begin
          legal = 1'b1;
          dec_a = 32'd0;
          dec_b = 32'd0;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sig_d   = sig_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    err_d   = err_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          rd_d = bus.instr[15:11];
          if (!legal) begin
            err_d   = 1'b1;
            we_d    = 1'b0;
            data_d  = 32'd0;
            vld_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            a_d   = dec_a;
            b_d   = dec_b;
            sig_d = funct;
            we_d  = !is_mul;
            if (is_mul) begin
              data_d  = 32'd0;
              cnt_d   = MUL_CNT0;
              state_d = S_MULW;
            end else begin
              cnt_d   = ALU_CNT0;
              state_d = S_EXEC;
            end
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 7'd0) begin
          data_d  = bus.alu_output;
          sig_d   = F_NOP;
          vld_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_MULW: begin
        if (cnt_q == 7'd0) begin
          sig_d   = F_NOP;
          a_d     = 32'd0;
          b_d     = 32'd0;
          cnt_d   = HILO_CNT0;
          state_d = S_HILO;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_HILO: begin
        if (cnt_q == 7'd0) begin
          vld_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          err_d   = 1'b0;
          sig_d   = F_NOP;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sig_q   <= F_NOP;
      data_q  <= 32'd0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sig_q   <= sig_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  // Gating with reset keeps in_ready low throughout the reset cycle itself.
  assign bus.in_ready   = (state_q == S_IDLE) && !reset;
  assign bus.alu_dataA  = a_q;
  assign bus.alu_dataB  = b_q;
  assign bus.alu_signal = sig_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_data   = data_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_we     = we_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural ALU/HI-LO datapath and a result scoreboard.
module tb_alu_issuer;
  logic clk = 1'b0;
  logic reset;
  alu_issuer_if bus ();

  alu_issuer #(.ALU_LAT(1), .MUL_CYCLES(32), .HILO_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath: one registered control stage, HI/LO written while MULTU is held.
  logic [5:0]  sig_r = 6'd0;
  logic [31:0] a_r = 32'd0, b_r = 32'd0, hi_r = 32'd0, lo_r = 32'd0;
  logic [63:0] prod;
  assign prod = {32'd0, a_r} * {32'd0, b_r};
  always @(posedge clk) begin
    sig_r <= bus.alu_signal;
    a_r   <= bus.alu_dataA;
    b_r   <= bus.alu_dataB;
    if (sig_r == 6'd25) {hi_r, lo_r} <= prod;
  end
  always_comb begin
    bus.alu_output = 32'd0;
    case (sig_r)
      6'd32: bus.alu_output = a_r + b_r;
      6'd34: bus.alu_output = a_r - b_r;
      6'd36: bus.alu_output = a_r & b_r;
      6'd37: bus.alu_output = a_r | b_r;
      6'd42: bus.alu_output = ($signed(a_r) < $signed(b_r)) ? 32'd1 : 32'd0;
      6'd2:  bus.alu_output = a_r >> b_r[4:0];
      6'd16: bus.alu_output = hi_r;
      6'd18: bus.alu_output = lo_r;
      default: bus.alu_output = 32'd0;
    endcase
  end

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [5:0] funct, input logic [4:0] rd, input logic [4:0] shamt,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_data, input logic exp_we, input logic exp_err,
                        input logic [5:0] exp_sig, input logic [31:0] exp_b,
                        input int exp_lat, input int exp_mul, input int hold);
    int n;
    int nmul;
    exp_t e;
    @(negedge clk);
    chk("in_ready_before", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.instr    = {6'd0, 5'd0, 5'd0, rd, shamt, funct};
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    sb.push_back('{data: exp_data, rd: rd, we: exp_we, err: exp_err});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sig_cycle1", {26'd0, bus.alu_signal}, {26'd0, exp_sig});
    chk("dataB_cycle1", bus.alu_dataB, exp_b);
    n = 1;
    nmul = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (bus.alu_signal === 6'd25) nmul++;
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("mul_cycles", nmul, exp_mul);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_data", bus.out_data, e.data);
      chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
      chk("out_we", {31'd0, bus.out_we}, {31'd0, e.we});
      chk("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
      chk("in_ready_resp", {31'd0, bus.in_ready}, 32'd0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", bus.out_data, e.data);
        chk("hold_err", {31'd0, bus.out_err}, {31'd0, e.err});
        chk("hold_sig", {26'd0, bus.alu_signal}, 32'd0);
        chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("valid_after", {31'd0, bus.out_valid}, 32'd0);
    chk("err_after", {31'd0, bus.out_err}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sig", {26'd0, bus.alu_signal}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_we", {31'd0, bus.out_we}, 32'd0);
    chk("rst_err", {31'd0, bus.out_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("idle_sig", {26'd0, bus.alu_signal}, 32'd0);
    end

    // funct rd shamt rs rt | data we err | sig dataB lat mul hold
    run_op(6'd32, 5'd3, 5'd0, 32'd5, 32'd7, 32'd12, 1'b1, 1'b0, 6'd32, 32'd7, 3, 0, 0);
    run_op(6'd34, 5'd4, 5'd0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 6'd34, 32'd5, 3, 0, 0);
    run_op(6'd42, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0, 6'd42, 32'd1, 3, 0, 0);
    run_op(6'd2, 5'd6, 5'd4, 32'h1234_5678, 32'h8000_0000, 32'h0800_0000, 1'b1, 1'b0, 6'd2, 32'd4, 3, 0, 1);
    run_op(6'd25, 5'd0, 5'd0, 32'h0000_FFFF, 32'h0001_0000, 32'd0, 1'b0, 1'b0, 6'd25, 32'h0001_0000, 34, 32, 0);
    run_op(6'd16, 5'd8, 5'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 1'b1, 1'b0, 6'd16, 32'd0, 3, 0, 0);
    run_op(6'd18, 5'd9, 5'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_0000, 1'b1, 1'b0, 6'd18, 32'd0, 3, 0, 0);
    run_op(6'h3F, 5'd4, 5'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1, 0, 5);

    // Reset in cycle 10 of a MULTU.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.instr    = {6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd25};
    bus.rs_val   = 32'd3;
    bus.rt_val   = 32'd4;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mrst_sig_before", {26'd0, bus.alu_signal}, 32'd25);
    chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_sig", {26'd0, bus.alu_signal}, 32'd0);
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_data", bus.out_data, 32'd0);
    chk("mrst_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("mrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

    run_op(6'd37, 5'd10, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b1, 1'b0, 6'd37, 32'h0000_000F, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
